// File: rtl/uart_rx_sequencer.sv
// UART receive sequencer: synchronises rx, times start/data/parity/stop by mid-bit sampling,
// and presents {error, byte} on RX_data with a one-cycle load strobe.
module uart_rx_sequencer #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter bit          PARITY_EN    = 1'b0,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [8:0] RX_data,
    output logic       load,
    output logic       busy
);

    localparam int unsigned   TW   = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] MID  = TW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } state_t;

    state_t          state_q;
    logic            rx_meta_q;
    logic            rx_s;
    logic [TW-1:0]   timer_q;
    logic [2:0]      idx_q;
    logic [7:0]      shift_q;
    logic            perr_q;
    logic            bit_end;

    assign bit_end = (timer_q == LAST);
    assign busy    = (state_q != StIdle);

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s      <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            timer_q <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            perr_q  <= 1'b0;
            RX_data <= '0;
            load    <= 1'b0;
        end else begin
            load <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (!rx_s) begin
                        state_q <= StStart;
                        timer_q <= '0;
                    end
                end
                StStart: begin
                    if (timer_q == MID) begin
                        timer_q <= '0;
                        if (!rx_s) begin
                            state_q <= StData;
                            idx_q   <= '0;
                            perr_q  <= 1'b0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                StData: begin
                    if (bit_end) begin
                        // LSB arrives first, so shift right and insert at the top.
                        shift_q <= {rx_s, shift_q[7:1]};
                        timer_q <= '0;
                        idx_q   <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_q <= PARITY_EN ? StParity : StStop;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                StParity: begin
                    if (bit_end) begin
                        perr_q  <= ((^shift_q) ^ rx_s) != PARITY_ODD;
                        timer_q <= '0;
                        state_q <= StStop;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                StStop: begin
                    if (bit_end) begin
                        RX_data <= {(~rx_s) | perr_q, shift_q};
                        load    <= 1'b1;
                        timer_q <= '0;
                        state_q <= rx_s ? StIdle : StBreak;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                StBreak: begin
                    if (rx_s) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Scoreboard bench for uart_rx_sequencer: one 8N1 instance and one even-parity instance.
module tb_uart_rx_sequencer;

    localparam int unsigned CPB = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_a;
    logic       rx_b;
    logic [8:0] RX_data_a;
    logic [8:0] RX_data_b;
    logic       load_a;
    logic       load_b;
    logic       busy_a;
    logic       busy_b;

    int n_checks = 0;
    int n_errors = 0;
    int unsigned cyc = 0;
    int unsigned last_load_a = 0;
    int unsigned start_cyc = 0;
    bit prev_a = 1'b0;
    bit prev_b = 1'b0;

    logic [8:0] q_a[$];
    logic [8:0] q_b[$];

    uart_rx_sequencer #(
        .CLKS_PER_BIT(CPB),
        .PARITY_EN   (1'b0),
        .PARITY_ODD  (1'b0)
    ) u_dut (
        .clk    (clk),
        .reset  (reset),
        .rx     (rx_a),
        .RX_data(RX_data_a),
        .load   (load_a),
        .busy   (busy_a)
    );

    uart_rx_sequencer #(
        .CLKS_PER_BIT(CPB),
        .PARITY_EN   (1'b1),
        .PARITY_ODD  (1'b0)
    ) u_dut_par (
        .clk    (clk),
        .reset  (reset),
        .rx     (rx_b),
        .RX_data(RX_data_b),
        .load   (load_b),
        .busy   (busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input bit sel, input logic v);
        if (sel) rx_b = v;
        else     rx_a = v;
        idle(CPB);
    endtask

    // Pushes the expected word, then drives start, 8 data bits, optional parity, stop.
    task automatic send_frame(input bit sel, input logic [7:0] data, input logic par_bit,
                              input logic stop_bit);
        logic perr;
        perr = sel ? ((^data) ^ par_bit) : 1'b0;
        if (sel) q_b.push_back({(~stop_bit) | perr, data});
        else     q_a.push_back({~stop_bit, data});
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, data[i]);
        if (sel) drive_bit(sel, par_bit);
        drive_bit(sel, stop_bit);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (load_a) begin
                check_eq("pulse_a", 16'(prev_a), 16'd0);
                check_eq("sb_has_a", 16'(q_a.size() != 0), 16'd1);
                if (q_a.size() != 0) check_eq("data_a", 16'(RX_data_a), 16'(q_a.pop_front()));
                last_load_a = cyc;
            end
            if (load_b) begin
                check_eq("pulse_b", 16'(prev_b), 16'd0);
                check_eq("sb_has_b", 16'(q_b.size() != 0), 16'd1);
                if (q_b.size() != 0) check_eq("data_b", 16'(RX_data_b), 16'(q_b.pop_front()));
            end
        end
        prev_a = load_a;
        prev_b = load_b;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        idle(3);
        check_eq("rst_data_a", 16'(RX_data_a), 16'd0);
        check_eq("rst_load_a", 16'(load_a), 16'd0);
        check_eq("rst_busy_a", 16'(busy_a), 16'd0);
        check_eq("rst_data_b", 16'(RX_data_b), 16'd0);
        check_eq("rst_load_b", 16'(load_b), 16'd0);
        check_eq("rst_busy_b", 16'(busy_b), 16'd0);
        reset = 1'b0;
        idle(5);

        // 8N1 0xA5 with latency from pin falling edge to load.
        start_cyc = cyc;
        send_frame(1'b0, 8'hA5, 1'b0, 1'b1);
        idle(4);
        check_eq("latency_a5", 16'(last_load_a - start_cyc), 16'd155);
        check_eq("busy_after_a5", 16'(busy_a), 16'd0);

        // Start-bit glitch: no load, back to idle.
        rx_a = 1'b0;
        idle(4);
        rx_a = 1'b1;
        idle(2);
        check_eq("glitch_busy_hi", 16'(busy_a), 16'd1);
        idle(20);
        check_eq("glitch_busy_lo", 16'(busy_a), 16'd0);

        // Framing error then held-low break line.
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0);
        idle(100);
        check_eq("break_busy", 16'(busy_a), 16'd1);
        rx_a = 1'b1;
        idle(4);
        check_eq("break_exit", 16'(busy_a), 16'd0);
        send_frame(1'b0, 8'h81, 1'b0, 1'b1);
        idle(4);

        // Even parity on the parity instance.
        send_frame(1'b1, 8'h07, 1'b1, 1'b1);
        idle(4);
        send_frame(1'b1, 8'h07, 1'b0, 1'b1);
        idle(4);
        check_eq("par_busy", 16'(busy_b), 16'd0);

        // Back-to-back frames with no idle gap.
        send_frame(1'b0, 8'h00, 1'b0, 1'b1);
        send_frame(1'b0, 8'hFF, 1'b0, 1'b1);
        idle(4);

        // Reset during data bit 4 of a partial 0xFF frame.
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b1);
        rx_a = 1'b1;
        idle(8);
        reset = 1'b1;
        #1;
        check_eq("midrst_data", 16'(RX_data_a), 16'd0);
        check_eq("midrst_load", 16'(load_a), 16'd0);
        check_eq("midrst_busy", 16'(busy_a), 16'd0);
        idle(3);
        reset = 1'b0;
        idle(5);
        check_eq("postrst_busy", 16'(busy_a), 16'd0);
        send_frame(1'b0, 8'h55, 1'b0, 1'b1);
        idle(4);

        for (int i = 0; i < 2000 && (q_a.size() != 0 || q_b.size() != 0); i++) idle(1);
        check_eq("drain_a", 16'(q_a.size()), 16'd0);
        check_eq("drain_b", 16'(q_b.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
